// File: rtl/aes_cipher_core_if.sv
// ---------------------------------------------------------------------------
// aes_cipher_core_if
//   Handshake/bus bundle between the AES cipher core, its plaintext source,
//   the round-key generator and the ciphertext sink.
//
//   Signals (widths in brackets):
//     pt[128], in_valid, in_ready          plaintext valid/ready input
//     key_advance                          one-cycle start pulse to roundkeygen
//     round_key[128], round_key_valid      round key stream from roundkeygen
//     ct[128], out_valid, out_ready        ciphertext valid/ready output
//     busy                                 core is not idle
//     key_err                              only when AES_KEY_TIMEOUT_EN is defined
//
//   Modports:
//     slave  : the cipher core's view
//     master : the surrounding environment's view
// ---------------------------------------------------------------------------
interface aes_cipher_core_if;
  logic [127:0] pt;
  logic         in_valid;
  logic         in_ready;
  logic         key_advance;
  logic [127:0] round_key;
  logic         round_key_valid;
  logic [127:0] ct;
  logic         out_valid;
  logic         out_ready;
  logic         busy;
`ifdef AES_KEY_TIMEOUT_EN
  logic         key_err;
`endif

  modport slave (
    input  pt, in_valid, round_key, round_key_valid, out_ready,
    output in_ready, key_advance, ct, out_valid, busy
`ifdef AES_KEY_TIMEOUT_EN
    , output key_err
`endif
  );

  modport master (
    output pt, in_valid, round_key, round_key_valid, out_ready,
    input  in_ready, key_advance, ct, out_valid, busy
`ifdef AES_KEY_TIMEOUT_EN
    , input key_err
`endif
  );
endinterface

// File: rtl/aes_cipher_core.sv
// ---------------------------------------------------------------------------
// aes_cipher_core
//   Iterative AES encryption datapath. Latches one plaintext block, pulses
//   key_advance to start the external key schedule, then applies one AES
//   round per round_key_valid pulse (NR+1 keys per block). The ciphertext is
//   presented on a valid/ready handshake and held until accepted.
//
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : aes_cipher_core_if.slave (pt/in_valid/in_ready, key_advance,
//              round_key/round_key_valid, ct/out_valid/out_ready, busy,
//              key_err when enabled)
//
//   Parameters:
//     NR      : cipher rounds (10, 12 or 14)
//     TIMEOUT : max cycles between round keys (AES_KEY_TIMEOUT_EN only)
//
//   Optional feature macro: AES_KEY_TIMEOUT_EN
//     Adds key_err and a key wait counter; a stalled key stream aborts the
//     block and returns to IDLE with state cleared.
//
//   Also contains aes_sbox, the combinational 8-bit S-box (GF(2^8) inverse
//   followed by the affine transform).
// ---------------------------------------------------------------------------
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p  = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); 0 maps to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq, acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  logic [7:0] w_inv;

  always_comb begin
    w_inv  = gf_inv(i_byte);
    o_byte = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
           ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
  end
endmodule

module aes_cipher_core #(
  parameter int NR      = 14,
  parameter int TIMEOUT = 15
) (
  input logic              clk,
  input logic              rst_n,
  aes_cipher_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT_KEY, DONE} state_t;

  localparam logic [3:0] NR4 = 4'(NR);

  if (!(NR == 10 || NR == 12 || NR == 14) || TIMEOUT < 2) begin : g_bad_param
    $error("aes_cipher_core: illegal NR or TIMEOUT");
  end

  state_t       r_state;
  logic [127:0] r_sreg;
  logic [3:0]   r_rnd;
  logic [127:0] r_ct;
  logic         r_out_valid;
  logic         r_key_adv;
  logic         r_busy;

  logic [127:0] w_sb, w_sr, w_mc;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  // Round counter holds at NR instead of wrapping.
  function automatic logic [3:0] rnd_sat_inc(input logic [3:0] r);
    return (r == NR4) ? r : r + 4'd1;
  endfunction

  // SubBytes: byte k is r_sreg[127-8k -: 8]
  for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (r_sreg[127-8*gi -: 8]),
      .o_byte (w_sb[127-8*gi -: 8])
    );
  end

  // ShiftRows (byte 4c+r sits at row r, column c) then MixColumns
  always_comb begin
    w_sr = '0;
    w_mc = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sr[127-8*(4*c+r) -: 8] = w_sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      w_mc[127-32*c -: 32] = mix_col(w_sr[127-32*c -: 32]);
    end
  end

`ifdef AES_KEY_TIMEOUT_EN
  localparam int              CW      = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] r_wait;
  logic          r_key_err;
  assign bus.key_err = r_key_err;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sreg      <= '0;
      r_rnd       <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
      r_key_adv   <= 1'b0;
      r_busy      <= 1'b0;
`ifdef AES_KEY_TIMEOUT_EN
      r_wait      <= '0;
      r_key_err   <= 1'b0;
`endif
    end else begin
      r_key_adv <= 1'b0;
`ifdef AES_KEY_TIMEOUT_EN
      r_key_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_sreg    <= bus.pt;
            r_rnd     <= '0;
            r_key_adv <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= WAIT_KEY;
`ifdef AES_KEY_TIMEOUT_EN
            r_wait    <= '0;
`endif
          end
        end
        WAIT_KEY: begin
          if (bus.round_key_valid) begin
            r_rnd <= rnd_sat_inc(r_rnd);
`ifdef AES_KEY_TIMEOUT_EN
            r_wait <= '0;
`endif
            if (r_rnd == 4'd0) begin
              r_sreg <= r_sreg ^ bus.round_key;
            end else if (r_rnd == NR4) begin
              // Final round skips MixColumns
              r_ct        <= w_sr ^ bus.round_key;
              r_out_valid <= 1'b1;
              r_state     <= DONE;
            end else begin
              r_sreg <= w_mc ^ bus.round_key;
            end
          end
`ifdef AES_KEY_TIMEOUT_EN
          else if (r_wait == TO_LAST) begin
            // Key stream stalled: drop the block without presenting ct
            r_key_err <= 1'b1;
            r_sreg    <= '0;
            r_busy    <= 1'b0;
            r_state   <= IDLE;
          end else begin
            r_wait <= r_wait + CW'(1);
          end
`endif
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (r_state == IDLE);
  assign bus.key_advance = r_key_adv;
  assign bus.ct          = r_ct;
  assign bus.out_valid   = r_out_valid;
  assign bus.busy        = r_busy;
endmodule
